// File: rtl/addr_dec_pkg.sv
// Shared definitions for the programmable 68k address decoder: FSM states,
// config register layout and the power-on memory map.
package addr_dec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_ACK,
        ST_TIMEOUT,
        ST_BERR
    } state_t;

    // Per-region register offsets within each block of four
    localparam int REG_BASE  = 0;
    localparam int REG_LIMIT = 1;
    localparam int REG_CTRL  = 2;

    // Global register offsets after the last region block
    localparam int GLB_FAULT_ADDR   = 0;
    localparam int GLB_FAULT_STATUS = 1;

    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_WS_LSB = 1;
    localparam int CTRL_WS_MSB = 4;
    localparam int WS_W        = CTRL_WS_MSB - CTRL_WS_LSB + 1;

    typedef struct packed {
        logic [31:0]     base;
        logic [31:0]     limit;
        logic [WS_W-1:0] ws;
        logic            en;
    } region_def_t;

    // Reset map mirrors the legacy fixed decoder; R1 overlaps R3 and wins by priority
    function automatic region_def_t def_region(input int r);
        case (r)
            0:       return '{base: 32'h0000_0000, limit: 32'h0000_7FFF, ws: 4'd0, en: 1'b1};
            1:       return '{base: 32'h0800_0000, limit: 32'h0803_FFFF, ws: 4'd0, en: 1'b1};
            2:       return '{base: 32'h0040_0000, limit: 32'h0040_FFFF, ws: 4'd1, en: 1'b1};
            3:       return '{base: 32'h0800_0000, limit: 32'h0BFF_FFFF, ws: 4'd2, en: 1'b1};
            default: return '{base: 32'h0000_0000, limit: 32'h0000_0000, ws: 4'd0, en: 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/addr_dec_region_match.sv
// Single-region window comparator: hit when enabled and base <= addr <= limit.
module addr_dec_region_match #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] limit_i,
    input  logic                  en_i,
    output logic                  match_o
);

    // An inverted window (base > limit) can never satisfy both bounds
    assign match_o = en_i && (addr_i >= base_i) && (addr_i <= limit_i);

endmodule

// File: rtl/prog_address_decoder.sv
// Programmable 68k address decoder: region chip selects, wait-state DTACK
// generation and bus-error timeout with first-fault address capture.
module prog_address_decoder
    import addr_dec_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_REGIONS    = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CFG_AW         = $clog2(4*NUM_REGIONS+2)
) (
    input  logic                   Clk,
    input  logic                   Reset_L,
    input  logic [ADDR_WIDTH-1:0]  Address,
    input  logic                   AS_L,
    output logic [NUM_REGIONS-1:0] Select_H,
    output logic                   Dtack_L,
    output logic                   Berr_L,
    input  logic                   CfgWrite_H,
    input  logic [CFG_AW-1:0]      CfgAddr,
    input  logic [31:0]            CfgWData,
    output logic [31:0]            CfgRData,
    output logic                   FaultValid_H
);

    localparam int CNT_W            = $clog2(TIMEOUT_CYCLES > 16 ? TIMEOUT_CYCLES : 16);
    localparam int FAULT_ADDR_IDX   = 4*NUM_REGIONS + GLB_FAULT_ADDR;
    localparam int FAULT_STATUS_IDX = 4*NUM_REGIONS + GLB_FAULT_STATUS;

    logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] region_base;
    logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] region_limit;
    logic [NUM_REGIONS-1:0][WS_W-1:0]       region_ws;
    logic [NUM_REGIONS-1:0]                 region_en;
    logic [NUM_REGIONS-1:0]                 match;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_REGIONS-1:0] sel_q;
    logic                   dtack_l_q;
    logic                   berr_l_q;
    logic                   fault_vld_q;
    logic [ADDR_WIDTH-1:0]  fault_addr_q;

    logic                   hit;
    logic [NUM_REGIONS-1:0] hit_sel;
    logic [WS_W-1:0]        hit_ws;
    logic                   fault_clr;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        localparam region_def_t DEF = def_region(g);

        logic [ADDR_WIDTH-1:0] base_q;
        logic [ADDR_WIDTH-1:0] limit_q;
        logic [WS_W-1:0]       ws_q;
        logic                  en_q;

        always_ff @(posedge Clk or negedge Reset_L) begin
            if (!Reset_L) begin
                base_q  <= DEF.base[ADDR_WIDTH-1:0];
                limit_q <= DEF.limit[ADDR_WIDTH-1:0];
                ws_q    <= DEF.ws;
                en_q    <= DEF.en;
            end else if (CfgWrite_H) begin
                if (CfgAddr == CFG_AW'(4*g + REG_BASE))
                    base_q <= CfgWData[ADDR_WIDTH-1:0];
                if (CfgAddr == CFG_AW'(4*g + REG_LIMIT))
                    limit_q <= CfgWData[ADDR_WIDTH-1:0];
                if (CfgAddr == CFG_AW'(4*g + REG_CTRL)) begin
                    en_q <= CfgWData[CTRL_EN_BIT];
                    ws_q <= CfgWData[CTRL_WS_MSB:CTRL_WS_LSB];
                end
            end
        end

        assign region_base[g]  = base_q;
        assign region_limit[g] = limit_q;
        assign region_ws[g]    = ws_q;
        assign region_en[g]    = en_q;

        addr_dec_region_match #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_match (
            .addr_i  (addr_q),
            .base_i  (base_q),
            .limit_i (limit_q),
            .en_i    (en_q),
            .match_o (match[g])
        );
    end

    // Lowest index wins: scan downward so the last assignment is the lowest hit
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        hit_ws  = '0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if (match[r]) begin
                hit        = 1'b1;
                hit_sel    = '0;
                hit_sel[r] = 1'b1;
                hit_ws     = region_ws[r];
            end
        end
    end

    always_comb begin
        CfgRData = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (CfgAddr == CFG_AW'(4*r + REG_BASE))
                CfgRData = 32'(region_base[r]);
            if (CfgAddr == CFG_AW'(4*r + REG_LIMIT))
                CfgRData = 32'(region_limit[r]);
            if (CfgAddr == CFG_AW'(4*r + REG_CTRL)) begin
                CfgRData[CTRL_EN_BIT]             = region_en[r];
                CfgRData[CTRL_WS_MSB:CTRL_WS_LSB] = region_ws[r];
            end
        end
        if (CfgAddr == CFG_AW'(FAULT_ADDR_IDX))
            CfgRData = 32'(fault_addr_q);
        if (CfgAddr == CFG_AW'(FAULT_STATUS_IDX))
            CfgRData[0] = fault_vld_q;
    end

    assign fault_clr = CfgWrite_H && (CfgAddr == CFG_AW'(FAULT_STATUS_IDX)) && CfgWData[0];

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            sel_q        <= '0;
            dtack_l_q    <= 1'b1;
            berr_l_q     <= 1'b1;
            fault_vld_q  <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            if (fault_clr)
                fault_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!AS_L) begin
                        addr_q  <= Address;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (AS_L) begin
                        state_q <= ST_IDLE;
                    end else if (hit) begin
                        sel_q <= hit_sel;
                        if (hit_ws == '0) begin
                            state_q <= ST_ACK;
                        end else begin
                            cnt_q   <= CNT_W'(hit_ws);
                            state_q <= ST_WAIT;
                        end
                    end else begin
                        cnt_q   <= CNT_W'(TIMEOUT_CYCLES - 1);
                        state_q <= ST_TIMEOUT;
                        // Capture after the clear above so a same-edge capture wins
                        if (!fault_vld_q) begin
                            fault_addr_q <= addr_q;
                            fault_vld_q  <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (AS_L) begin
                        sel_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_W'(1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    if (AS_L) begin
                        sel_q     <= '0;
                        dtack_l_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        dtack_l_q <= 1'b0;
                    end
                end
                ST_TIMEOUT: begin
                    if (AS_L) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        berr_l_q <= 1'b0;
                        state_q  <= ST_BERR;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_BERR: begin
                    if (AS_L) begin
                        berr_l_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    sel_q     <= '0;
                    dtack_l_q <= 1'b1;
                    berr_l_q  <= 1'b1;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign Select_H     = sel_q;
    assign Dtack_L      = dtack_l_q;
    assign Berr_L       = berr_l_q;
    assign FaultValid_H = fault_vld_q;

endmodule

// File: tb/tb_prog_address_decoder.sv
// Scoreboarded bench for prog_address_decoder with the default 8-region map.
module tb_prog_address_decoder;

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] dk;
        logic [7:0] bk;
        logic       rel;
        logic       ovl;
    } res_t;

    localparam int BUDGET = 90;
    localparam int BERR_K = 1 + 64;

    logic        Clk = 1'b0;
    logic        Reset_L = 1'b0;
    logic [31:0] Address = '0;
    logic        AS_L = 1'b1;
    logic [7:0]  Select_H;
    logic        Dtack_L;
    logic        Berr_L;
    logic        CfgWrite_H = 1'b0;
    logic [5:0]  CfgAddr = '0;
    logic [31:0] CfgWData = '0;
    logic [31:0] CfgRData;
    logic        FaultValid_H;

    int   vectors = 0;
    int   miscompares = 0;
    res_t exp_q[$];
    res_t obs_q[$];

    prog_address_decoder dut (
        .Clk          (Clk),
        .Reset_L      (Reset_L),
        .Address      (Address),
        .AS_L         (AS_L),
        .Select_H     (Select_H),
        .Dtack_L      (Dtack_L),
        .Berr_L       (Berr_L),
        .CfgWrite_H   (CfgWrite_H),
        .CfgAddr      (CfgAddr),
        .CfgWData     (CfgWData),
        .CfgRData     (CfgRData),
        .FaultValid_H (FaultValid_H)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cfg_write(input logic [5:0] idx, input logic [31:0] data);
        CfgWrite_H = 1'b1;
        CfgAddr    = idx;
        CfgWData   = data;
        @(posedge Clk); #1;
        CfgWrite_H = 1'b0;
    endtask

    // Runs one bus cycle and records edge indices (relative to edge N) of events
    task automatic obs_access(input logic [31:0] addr, input int abort_k, input int mid_k,
                              input logic [5:0] mid_idx, input logic [31:0] mid_data);
        res_t o;
        int   k;
        bit   done;
        o       = '0;
        Address = addr;
        AS_L    = 1'b0;
        @(posedge Clk); #1;
        k    = 0;
        done = 0;
        while (!done && k < BUDGET) begin
            @(posedge Clk); #1;
            k++;
            CfgWrite_H = 1'b0;
            if (k == 1) o.sel = Select_H;
            if (!Dtack_L && o.dk == 0) o.dk = 8'(k);
            if (!Berr_L && o.bk == 0) o.bk = 8'(k);
            if (!Dtack_L && !Berr_L) o.ovl = 1'b1;
            if (k == mid_k) begin
                CfgWrite_H = 1'b1;
                CfgAddr    = mid_idx;
                CfgWData   = mid_data;
            end
            if (k == abort_k || (o.dk != 0 && k > int'(o.dk)) || (o.bk != 0 && k > int'(o.bk)))
                done = 1;
        end
        CfgWrite_H = 1'b0;
        AS_L       = 1'b1;
        @(posedge Clk); #1;
        o.rel = (Select_H == 8'h00) && Dtack_L && Berr_L;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        Reset_L = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        vectors++;
        if ({Select_H, Dtack_L, Berr_L, FaultValid_H} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got sel=%h dtack=%b berr=%b fv=%b, want 00 1 1 0",
                     Select_H, Dtack_L, Berr_L, FaultValid_H);
        end
        Reset_L = 1'b1;
        CfgAddr = 6'd13; #1;
        vectors++;
        if (CfgRData !== 32'h0BFF_FFFF) begin
            miscompares++; $display("FAIL reset_r3_limit: got %h want 0BFFFFFF", CfgRData);
        end
        CfgAddr = 6'd10; #1;
        vectors++;
        if (CfgRData !== 32'h0000_0003) begin
            miscompares++; $display("FAIL reset_r2_ctrl: got %h want 00000003", CfgRData);
        end
        CfgAddr = 6'd18; #1;
        vectors++;
        if (CfgRData !== 32'h0000_0000) begin
            miscompares++; $display("FAIL reset_r4_ctrl: got %h want 00000000", CfgRData);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_defaults_and_priority();
        exp_q.push_back('{sel: 8'h01, dk: 8'd2, bk: 8'd0, rel: 1'b1, ovl: 1'b0});
        obs_access(32'h0000_1000, 0, 0, 6'd0, 32'h0);
        exp_q.push_back('{sel: 8'h02, dk: 8'd2, bk: 8'd0, rel: 1'b1, ovl: 1'b0});
        obs_access(32'h0800_0010, 0, 0, 6'd0, 32'h0);
        exp_q.push_back('{sel: 8'h08, dk: 8'd4, bk: 8'd0, rel: 1'b1, ovl: 1'b0});
        obs_access(32'h0900_0000, 0, 0, 6'd0, 32'h0);
        exp_q.push_back('{sel: 8'h04, dk: 8'd3, bk: 8'd0, rel: 1'b1, ovl: 1'b0});
        obs_access(32'h0040_0004, 0, 0, 6'd0, 32'h0);
        while (exp_q.size() != 0) begin
            res_t e = exp_q.pop_front();
            res_t o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL defaults_access: got sel=%h dtack@%0d berr@%0d rel=%b ovl=%b, want sel=%h dtack@%0d berr@%0d rel=1 ovl=0",
                         o.sel, o.dk, o.bk, o.rel, o.ovl, e.sel, e.dk, e.bk);
            end
        end
    endtask

    task automatic test_unmapped();
        exp_q.push_back('{sel: 8'h00, dk: 8'd0, bk: 8'(BERR_K), rel: 1'b1, ovl: 1'b0});
        obs_access(32'h2000_0000, 0, 0, 6'd0, 32'h0);
        vectors++;
        if (FaultValid_H !== 1'b1) begin
            miscompares++; $display("FAIL fault_valid_set: got %b want 1", FaultValid_H);
        end
        exp_q.push_back('{sel: 8'h00, dk: 8'd0, bk: 8'(BERR_K), rel: 1'b1, ovl: 1'b0});
        obs_access(32'h3000_0000, 0, 0, 6'd0, 32'h0);
        cfg_write(6'd32, 32'hDEAD_BEEF);
        CfgAddr = 6'd32; #1;
        vectors++;
        if (CfgRData !== 32'h2000_0000) begin
            miscompares++; $display("FAIL fault_addr_first: got %h want 20000000", CfgRData);
        end
        cfg_write(6'd33, 32'h1);
        vectors++;
        if (FaultValid_H !== 1'b0) begin
            miscompares++; $display("FAIL fault_clear: got %b want 0", FaultValid_H);
        end
        while (exp_q.size() != 0) begin
            res_t e = exp_q.pop_front();
            res_t o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL unmapped_access: got sel=%h dtack@%0d berr@%0d rel=%b ovl=%b, want sel=%h dtack@%0d berr@%0d rel=1 ovl=0",
                         o.sel, o.dk, o.bk, o.rel, o.ovl, e.sel, e.dk, e.bk);
            end
        end
    endtask

    task automatic test_reprogram();
        cfg_write(6'd16, 32'h00F0_0000);
        cfg_write(6'd17, 32'h00F0_FFFF);
        cfg_write(6'd18, 32'h0000_000B);
        cfg_write(6'd19, 32'hFFFF_FFFF);
        CfgAddr = 6'd19; #1;
        vectors++;
        if (CfgRData !== 32'h0) begin
            miscompares++; $display("FAIL reserved_read: got %h want 00000000", CfgRData);
        end
        exp_q.push_back('{sel: 8'h10, dk: 8'd7, bk: 8'd0, rel: 1'b1, ovl: 1'b0});
        obs_access(32'h00F0_0004, 0, 0, 6'd0, 32'h0);
        cfg_write(6'd16, 32'h00F1_0000);
        exp_q.push_back('{sel: 8'h00, dk: 8'd0, bk: 8'(BERR_K), rel: 1'b1, ovl: 1'b0});
        obs_access(32'h00F0_0004, 0, 0, 6'd0, 32'h0);
        CfgAddr = 6'd32; #1;
        vectors++;
        if (CfgRData !== 32'h00F0_0004) begin
            miscompares++; $display("FAIL fault_addr_recapture: got %h want 00F00004", CfgRData);
        end
        while (exp_q.size() != 0) begin
            res_t e = exp_q.pop_front();
            res_t o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reprogram_access: got sel=%h dtack@%0d berr@%0d rel=%b ovl=%b, want sel=%h dtack@%0d berr@%0d rel=1 ovl=0",
                         o.sel, o.dk, o.bk, o.rel, o.ovl, e.sel, e.dk, e.bk);
            end
        end
    endtask

    task automatic test_abort();
        cfg_write(6'd16, 32'h00F0_0000);
        cfg_write(6'd18, 32'h0000_001F);
        exp_q.push_back('{sel: 8'h10, dk: 8'd0, bk: 8'd0, rel: 1'b1, ovl: 1'b0});
        obs_access(32'h00F0_0010, 5, 0, 6'd0, 32'h0);
        exp_q.push_back('{sel: 8'h00, dk: 8'd0, bk: 8'd0, rel: 1'b1, ovl: 1'b0});
        obs_access(32'h4000_0000, 10, 0, 6'd0, 32'h0);
        exp_q.push_back('{sel: 8'h01, dk: 8'd2, bk: 8'd0, rel: 1'b1, ovl: 1'b0});
        obs_access(32'h0000_7FFF, 0, 0, 6'd0, 32'h0);
        while (exp_q.size() != 0) begin
            res_t e = exp_q.pop_front();
            res_t o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL abort_access: got sel=%h dtack@%0d berr@%0d rel=%b ovl=%b, want sel=%h dtack@%0d berr@%0d rel=1 ovl=0",
                         o.sel, o.dk, o.bk, o.rel, o.ovl, e.sel, e.dk, e.bk);
            end
        end
    endtask

    task automatic test_cfg_mid_access();
        exp_q.push_back('{sel: 8'h08, dk: 8'd4, bk: 8'd0, rel: 1'b1, ovl: 1'b0});
        obs_access(32'h0900_0000, 0, 1, 6'd14, 32'h0000_0001);
        exp_q.push_back('{sel: 8'h08, dk: 8'd2, bk: 8'd0, rel: 1'b1, ovl: 1'b0});
        obs_access(32'h0900_0000, 0, 0, 6'd0, 32'h0);
        while (exp_q.size() != 0) begin
            res_t e = exp_q.pop_front();
            res_t o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL cfg_mid_access: got sel=%h dtack@%0d berr@%0d rel=%b ovl=%b, want sel=%h dtack@%0d berr@%0d rel=1 ovl=0",
                         o.sel, o.dk, o.bk, o.rel, o.ovl, e.sel, e.dk, e.bk);
            end
        end
    endtask

    task automatic test_reset_mid_ack();
        Address = 32'h0000_1000;
        AS_L    = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        vectors++;
        if ({Select_H, Dtack_L} !== {8'h01, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_ack_state: got sel=%h dtack=%b want 01 0", Select_H, Dtack_L);
        end
        #1 Reset_L = 1'b0;
        #1;
        vectors++;
        if ({Select_H, Dtack_L, Berr_L} !== {8'h00, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset: got sel=%h dtack=%b berr=%b want 00 1 1", Select_H, Dtack_L, Berr_L);
        end
        CfgAddr = 6'd14; #1;
        vectors++;
        if (CfgRData !== 32'h0000_0005) begin
            miscompares++; $display("FAIL reset_r3_ctrl_restored: got %h want 00000005", CfgRData);
        end
        AS_L = 1'b1;
        @(posedge Clk); #1;
        Reset_L = 1'b1;
        @(posedge Clk); #1;
        exp_q.push_back('{sel: 8'h08, dk: 8'd4, bk: 8'd0, rel: 1'b1, ovl: 1'b0});
        obs_access(32'h0900_0000, 0, 0, 6'd0, 32'h0);
        exp_q.push_back('{sel: 8'h00, dk: 8'd0, bk: 8'(BERR_K), rel: 1'b1, ovl: 1'b0});
        obs_access(32'h00F0_0004, 0, 0, 6'd0, 32'h0);
        while (exp_q.size() != 0) begin
            res_t e = exp_q.pop_front();
            res_t o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL post_reset_access: got sel=%h dtack@%0d berr@%0d rel=%b ovl=%b, want sel=%h dtack@%0d berr@%0d rel=1 ovl=0",
                         o.sel, o.dk, o.bk, o.rel, o.ovl, e.sel, e.dk, e.bk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_defaults_and_priority();
        test_unmapped();
        test_reprogram();
        test_abort();
        test_cfg_mid_access();
        test_reset_mid_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
